// File: rtl/ram_access_arbiter.sv
// Two-port round-robin arbiter that turns read/write requests into the RAM's
// two-word command sequences and returns read data, or a timeout error, to the owner.
`timescale 1ns/1ps
module ram_access_arbiter #(
    parameter int RSP_TIMEOUT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       we0,
    input  logic [7:0] addr0,
    input  logic [7:0] wdata0,
    output logic       gnt0,
    output logic       done0,
    output logic       err0,
    output logic [7:0] rdata0,
    input  logic       req1,
    input  logic       we1,
    input  logic [7:0] addr1,
    input  logic [7:0] wdata1,
    output logic       gnt1,
    output logic       done1,
    output logic       err1,
    output logic [7:0] rdata1,
    output logic [9:0] ram_din,
    output logic       ram_rx_valid,
    input  logic [7:0] ram_dout,
    input  logic       ram_tx_valid,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR    = 3'd1,
        WR_DATA = 3'd2,
        RD_CMD  = 3'd3,
        RD_WAIT = 3'd4
    } state_t;

    localparam logic [3:0] TIMEOUT_CNT = 4'(RSP_TIMEOUT);

    logic [1:0]      req_vec;
    logic [1:0]      we_vec;
    logic [1:0][7:0] addr_vec;
    logic [1:0][7:0] wdata_vec;

    assign req_vec   = {req1, req0};
    assign we_vec    = {we1, we0};
    assign addr_vec  = {addr1, addr0};
    assign wdata_vec = {wdata1, wdata0};

    state_t          state_reg, state_next;
    logic            last_grant_reg, last_grant_next;
    logic            port_reg, port_next;
    logic            we_reg, we_next;
    logic [7:0]      wdata_reg, wdata_next;
    logic [3:0]      cnt_reg, cnt_next;
    logic [1:0]      gnt_reg, gnt_next;
    logic [1:0]      done_reg, done_next;
    logic [1:0]      err_reg, err_next;
    logic [1:0][7:0] rdata_reg, rdata_next;
    logic [9:0]      ram_din_reg, ram_din_next;
    logic            rx_valid_reg, rx_valid_next;
    logic            busy_reg, busy_next;
    logic            sel;
    logic [3:0]      cnt_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            port_reg       <= 1'b0;
            we_reg         <= 1'b0;
            wdata_reg      <= 8'h00;
            cnt_reg        <= 4'd0;
            gnt_reg        <= 2'b00;
            done_reg       <= 2'b00;
            err_reg        <= 2'b00;
            rdata_reg      <= '0;
            ram_din_reg    <= 10'h000;
            rx_valid_reg   <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            port_reg       <= port_next;
            we_reg         <= we_next;
            wdata_reg      <= wdata_next;
            cnt_reg        <= cnt_next;
            gnt_reg        <= gnt_next;
            done_reg       <= done_next;
            err_reg        <= err_next;
            rdata_reg      <= rdata_next;
            ram_din_reg    <= ram_din_next;
            rx_valid_reg   <= rx_valid_next;
            busy_reg       <= busy_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        port_next       = port_reg;
        we_next         = we_reg;
        wdata_next      = wdata_reg;
        cnt_next        = cnt_reg;
        gnt_next        = 2'b00;
        done_next       = 2'b00;
        err_next        = 2'b00;
        rdata_next      = rdata_reg;
        ram_din_next    = ram_din_reg;
        rx_valid_next   = 1'b0;
        sel             = 1'b0;
        cnt_inc         = cnt_reg + 4'd1;

        case (state_reg)
            IDLE: begin
                if (req_vec != 2'b00) begin
                    // A tie goes to the port that did not win the last tie.
                    if (req_vec == 2'b11) begin
                        sel             = ~last_grant_reg;
                        last_grant_next = sel;
                    end else begin
                        sel = req_vec[1];
                    end
                    port_next      = sel;
                    we_next        = we_vec[sel];
                    wdata_next     = wdata_vec[sel];
                    gnt_next[sel]  = 1'b1;
                    ram_din_next   = {(we_vec[sel] ? 2'b00 : 2'b10), addr_vec[sel]};
                    rx_valid_next  = 1'b1;
                    state_next     = ADDR;
                end
            end
            ADDR: begin
                rx_valid_next = 1'b1;
                if (we_reg) begin
                    ram_din_next = {2'b01, wdata_reg};
                    state_next   = WR_DATA;
                end else begin
                    ram_din_next = {2'b11, 8'h00};
                    state_next   = RD_CMD;
                end
            end
            WR_DATA: begin
                done_next[port_reg] = 1'b1;
                state_next          = IDLE;
            end
            RD_CMD: begin
                cnt_next   = 4'd0;
                state_next = RD_WAIT;
            end
            RD_WAIT: begin
                if (ram_tx_valid) begin
                    rdata_next[port_reg] = ram_dout;
                    done_next[port_reg]  = 1'b1;
                    state_next           = IDLE;
                end else begin
                    cnt_next = cnt_inc;
                    if (cnt_inc == TIMEOUT_CNT) begin
                        done_next[port_reg] = 1'b1;
                        err_next[port_reg]  = 1'b1;
                        state_next          = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    assign gnt0         = gnt_reg[0];
    assign gnt1         = gnt_reg[1];
    assign done0        = done_reg[0];
    assign done1        = done_reg[1];
    assign err0         = err_reg[0];
    assign err1         = err_reg[1];
    assign rdata0       = rdata_reg[0];
    assign rdata1       = rdata_reg[1];
    assign ram_din      = ram_din_reg;
    assign ram_rx_valid = rx_valid_reg;
    assign busy         = busy_reg;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed plus randomized bench for ram_access_arbiter, with a small RAM stub
// and a transaction-level reference model of arbitration, memory and read results.
`timescale 1ns/1ps
module tb_ram_access_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [7:0] addr0 = 8'h00, wdata0 = 8'h00, addr1 = 8'h00, wdata1 = 8'h00;
    logic       gnt0, done0, err0, gnt1, done1, err1;
    logic [7:0] rdata0, rdata1;
    logic [9:0] ram_din;
    logic       ram_rx_valid;
    logic [7:0] ram_dout = 8'h00;
    logic       ram_tx_valid = 1'b0;
    logic       busy;

    ram_access_arbiter #(.RSP_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .done0(done0), .err0(err0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .done1(done1), .err1(err1), .rdata1(rdata1),
        .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
        .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    // RAM stub: 00 set address, 01 write data, 10 set address and clear tx_valid,
    // 11 read (suppressed while mute is set, to force a timeout).
    logic [7:0] ram_mem [256];
    logic [7:0] ram_addr = 8'h00;
    logic       mute = 1'b0;
    always @(posedge clk) begin
        if (ram_rx_valid) begin
            case (ram_din[9:8])
                2'b00: begin ram_addr <= ram_din[7:0]; ram_tx_valid <= 1'b0; end
                2'b01: begin ram_mem[ram_addr] <= ram_din[7:0]; ram_tx_valid <= 1'b0; end
                2'b10: begin ram_addr <= ram_din[7:0]; ram_tx_valid <= 1'b0; end
                default: begin
                    if (!mute) begin
                        ram_dout     <= ram_mem[ram_addr];
                        ram_tx_valid <= 1'b1;
                    end
                end
            endcase
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state
    logic [7:0] model_mem [256];
    logic [7:0] model_rdata [2];
    bit         model_last = 1'b1;
    int         last_gnt_cyc = 0;
    int         n_pass = 0;
    int         n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int pick(input bit r0, input bit r1);
        int p;
        if (r0 && r1) begin
            p = model_last ? 0 : 1;
            model_last = (p == 1);
        end else begin
            p = r1 ? 1 : 0;
        end
        return p;
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_gnt"}, {gnt1, gnt0}, 2'b00);
        chk({tag, "_done"}, {done1, done0}, 2'b00);
        chk({tag, "_err"}, {err1, err0}, 2'b00);
        chk({tag, "_rdata0"}, rdata0, model_rdata[0]);
        chk({tag, "_rdata1"}, rdata1, model_rdata[1]);
        chk({tag, "_din"}, ram_din, 10'h000);
        chk({tag, "_rxv"}, ram_rx_valid, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    // Follows one transaction from grant to done, checking every registered output.
    task automatic expect_txn(input int port, input bit we, input logic [7:0] a,
                              input logic [7:0] wd, input bit to, input bit hold,
                              input int gap_exp);
        int   waited = 0;
        bit   got = 1'b0;
        int   n;
        logic [1:0] mask;
        mask = (port == 1) ? 2'b10 : 2'b01;
        while (!got && waited < 30) begin
            @(negedge clk);
            waited++;
            if (gnt0 || gnt1) got = 1'b1;
        end
        chk("gnt_seen", got, 1'b1);
        if (!got) return;
        chk("gnt_port", {gnt1, gnt0}, mask);
        if (gap_exp != 0) chk("gnt_gap", cyc - last_gnt_cyc, gap_exp);
        last_gnt_cyc = cyc;
        if (!hold) begin
            if (port == 0) req0 = 1'b0; else req1 = 1'b0;
        end
        chk("word0", ram_din, {(we ? 2'b00 : 2'b10), a});
        chk("word0_rxv", ram_rx_valid, 1'b1);
        chk("word0_busy", busy, 1'b1);
        @(negedge clk);
        chk("word1", ram_din, we ? {2'b01, wd} : {2'b11, 8'h00});
        chk("word1_rxv", ram_rx_valid, 1'b1);
        chk("word1_gnt", {gnt1, gnt0}, 2'b00);
        if (!we) chk("stale_txv", ram_tx_valid, 1'b0);
        @(negedge clk);
        chk("post_rxv", ram_rx_valid, 1'b0);
        if (we) begin
            model_mem[a] = wd;
        end else begin
            chk("early_done", {done1, done0}, 2'b00);
            n = to ? 4 : 1;
            for (int k = 0; k < n; k++) begin
                @(negedge clk);
                if (k < n - 1) begin
                    chk("wait_done", {done1, done0}, 2'b00);
                    chk("wait_rxv", ram_rx_valid, 1'b0);
                end
            end
            if (!to) model_rdata[port] = model_mem[a];
        end
        chk("done", {done1, done0}, mask);
        chk("err", {err1, err0}, to ? mask : 2'b00);
        chk("rdata0", rdata0, model_rdata[0]);
        chk("rdata1", rdata1, model_rdata[1]);
        chk("busy_end", busy, 1'b0);
        $display("txn port=%0d %s addr=%02h wdata=%02h timeout=%0d rdata0=%02h rdata1=%02h",
                 port, we ? "WR" : "RD", a, wd, to, rdata0, rdata1);
    endtask

    bit         pend [2];
    bit         pwe [2];
    bit         pto [2];
    logic [7:0] paddr [2];
    logic [7:0] pwd [2];

    initial begin
        int p;
        for (int i = 0; i < 256; i++) begin
            ram_mem[i]   = 8'h00;
            model_mem[i] = 8'h00;
        end
        model_rdata[0] = 8'h00;
        model_rdata[1] = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        chk_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Write then read on port 0
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h10; wdata0 = 8'hA5;
        expect_txn(pick(1'b1, 1'b0), 1'b1, 8'h10, 8'hA5, 1'b0, 1'b0, 0);
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
        expect_txn(pick(1'b1, 1'b0), 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 0);

        // Preload 8'h11 at 1 and 8'h22 at 2
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h01; wdata0 = 8'h11;
        expect_txn(pick(1'b1, 1'b0), 1'b1, 8'h01, 8'h11, 1'b0, 1'b0, 0);
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h02; wdata0 = 8'h22;
        expect_txn(pick(1'b1, 1'b0), 1'b1, 8'h02, 8'h22, 1'b0, 1'b0, 0);

        // Both ports reading with requests held: grants alternate
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h01;
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h02;
        for (int i = 0; i < 4; i++) begin
            p = pick(1'b1, 1'b1);
            chk("alt_order", p, i % 2);
            expect_txn(p, 1'b0, (p == 0) ? 8'h01 : 8'h02, 8'h00, 1'b0, 1'b1, 0);
        end
        req0 = 1'b0; req1 = 1'b0;

        // Back-to-back reads on port 1: second read must not see stale data
        @(negedge clk);
        req1 = 1'b1; addr1 = 8'h01;
        expect_txn(pick(1'b0, 1'b1), 1'b0, 8'h01, 8'h00, 1'b0, 1'b1, 0);
        addr1 = 8'h02;
        expect_txn(pick(1'b0, 1'b1), 1'b0, 8'h02, 8'h00, 1'b0, 1'b0, 0);
        chk("b2b_rdata1", rdata1, 8'h22);

        // Read timeout on port 1
        @(negedge clk);
        mute = 1'b1;
        req1 = 1'b1; addr1 = 8'h10;
        expect_txn(pick(1'b0, 1'b1), 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 0);
        chk("to_rdata1_kept", rdata1, 8'h22);
        mute = 1'b0;

        // Reset while in RD_CMD
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h02;
        begin
            int w = 0;
            while (!gnt0 && w < 30) begin @(negedge clk); w++; end
            chk("rst_gnt0", gnt0, 1'b1);
        end
        req0 = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        model_last = 1'b1;
        model_rdata[0] = 8'h00;
        model_rdata[1] = 8'h00;
        #1;
        chk_idle("midrst");
        repeat (2) begin
            @(negedge clk);
            chk("midrst_nodone", {done1, done0}, 2'b00);
        end
        rst_n = 1'b1;
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h05; wdata0 = 8'h5A;
        expect_txn(pick(1'b1, 1'b0), 1'b1, 8'h05, 8'h5A, 1'b0, 1'b0, 0);

        // Held writes on port 0: a grant every 3 cycles
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h20; wdata0 = 8'h01;
        expect_txn(pick(1'b1, 1'b0), 1'b1, 8'h20, 8'h01, 1'b0, 1'b1, 0);
        addr0 = 8'h21; wdata0 = 8'h02;
        expect_txn(pick(1'b1, 1'b0), 1'b1, 8'h21, 8'h02, 1'b0, 1'b1, 3);
        addr0 = 8'h22; wdata0 = 8'h03;
        expect_txn(pick(1'b1, 1'b0), 1'b1, 8'h22, 8'h03, 1'b0, 1'b0, 3);

        // Randomized traffic against the model
        pend[0] = 1'b0; pend[1] = 1'b0;
        for (int it = 0; it < 40; it++) begin
            for (int q = 0; q < 2; q++) begin
                if (!pend[q] && ($urandom_range(0, 2) != 0)) begin
                    pend[q]  = 1'b1;
                    pwe[q]   = $urandom_range(0, 1) == 1;
                    paddr[q] = 8'($urandom_range(0, 15));
                    pwd[q]   = 8'($urandom);
                    pto[q]   = !pwe[q] && ($urandom_range(0, 5) == 0);
                end
            end
            if (!pend[0] && !pend[1]) begin
                pend[0] = 1'b1; pwe[0] = 1'b0; paddr[0] = 8'($urandom_range(0, 15));
                pwd[0] = 8'h00; pto[0] = 1'b0;
            end
            req0 = pend[0]; we0 = pwe[0]; addr0 = paddr[0]; wdata0 = pwd[0];
            req1 = pend[1]; we1 = pwe[1]; addr1 = paddr[1]; wdata1 = pwd[1];
            p = pick(pend[0], pend[1]);
            mute = pto[p];
            expect_txn(p, pwe[p], paddr[p], pwd[p], pto[p], 1'b0, 0);
            pend[p] = 1'b0;
            mute = 1'b0;
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("final_busy", busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
